li_expander: RTL and testbench
==============================

// Module: li_expander
// PURPOSE
//   Inverse of the immediate extender: takes a 32-bit constant plus a destination register.
//   Emits the minimal MIPS instruction sequence that loads it: addiu, ori, lui, or lui+ori.
//   Feeds the instruction-generation/assembler path. Hands each word to a consumer over a
//   valid/ready stream.
//   Each emitted immediate, when passed back through the extender, reproduces the constant.
// PARAMETERS
//   USE_ADDIU  1  1: a value that sign-extends from 16 bits emits a single addiu.
//                 0: never emit addiu; such values take the ori/lui/lui+ori rules.
// PORTS
//   clk        in   1   clock; all state updates on rising edge
//   reset      in   1   synchronous, active-high
//   in_valid   in   1   request present
//   in_ready   out  1   block accepts a request this cycle
//   in_value   in   32  constant to load
//   in_rt      in   5   destination register number
//   out_valid  out  1   out_word valid
//   out_ready  in   1   consumer accepts out_word this cycle
//   out_word   out  32  MIPS instruction word
//   out_last   out  1   out_word is the final word of the current request
// BEHAVIOUR
//   Reset values: in_ready=1, out_valid=0, out_word=0, out_last=0, state=IDLE.
//   Encodings (lo = value[15:0], hi = value[31:16]):
//     addiu = {6'b001001, 5'd0, rt, lo}
//     ori0  = {6'b001101, 5'd0, rt, lo}
//     lui   = {6'b001111, 5'd0, rt, hi}
//     orir  = {6'b001101, rt, rt, lo}
//   Selection, priority order, computed on the registered value:
//     1. USE_ADDIU && hi == {16{lo[15]}}  -> addiu (1 word)
//     2. hi == 0                          -> ori0  (1 word)
//     3. lo == 0                          -> lui   (1 word)
//     4. otherwise                        -> lui, then orir (2 words)
//   FSM states: IDLE, EMIT1, EMIT2.
//     IDLE:  in_ready=1. When in_valid, capture in_value/in_rt into registers and go to EMIT1.
//     EMIT1: out_valid=1, first word. On out_valid&&out_ready, go to EMIT2 if case 4,
//            otherwise go to IDLE.
//     EMIT2: out_valid=1, word=orir. On handshake, go to IDLE.
//   in_ready=1 only in IDLE. The FSM never accepts a new request in the cycle a word
//     completes, so there is at least one idle cycle between requests.
//   Latency: first word is valid in the cycle after acceptance. Outputs are registered.
//   Stall: while out_valid && !out_ready, out_word and out_last hold stable; state unchanged.
//   out_last=1 on the single word of cases 1-3 and on the orir word of case 4.
//     out_last=0 on the lui word of case 4.
//   in_rt==0: emitted normally. No suppression.
//   value 0: addiu rt,$0,0 (USE_ADDIU=1); ori0 with lo=0 (USE_ADDIU=0).
//   0x00008000: not sign-fit, so ori0 is emitted.
//   0xFFFF0000: lui 0xFFFF.
//   Input changes while not in IDLE are ignored. The captured copy is used.
//   Reset in any state: next cycle is IDLE, out_valid=0, the in-flight request is dropped,
//     and no partial pair completes.
// TESTING (in_rt=8 unless stated; USE_ADDIU=1 unless stated)
//   0x00000005 -> one word 0x24080005, out_last=1; in_ready high again 1 cycle after handshake.
//   0xFFFF8000, rt=9 -> 0x24098000, out_last=1.
//   0x0000ABCD -> 0x3408ABCD.
//   0x12340000 -> 0x3C081234.
//   0x12345678, out_ready low 3 cycles:
//     0x3C081234 (last=0) held stable for all 3 cycles, then 0x35085678 (last=1).
//   USE_ADDIU=0, 0xFFFFFFFF -> 0x3C08FFFF then 0x3508FFFF.
//   Reset pulsed in EMIT2 -> next cycle out_valid=0, in_ready=1, and no orir word appears.

Source files
------------

// File: rtl/li_expander_if.sv
// Request/response stream bundle for the constant-load expander.
//   in_*  : constant + destination register from the requester (valid/ready)
//   out_* : generated MIPS instruction words to the consumer (valid/ready, last flag)
interface li_expander_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [4:0]  in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_last;

  // slave: the expander itself
  modport slave (
    input  in_valid, in_value, in_rt, out_ready,
    output in_ready, out_valid, out_word, out_last
  );

  // master: the requester/consumer environment around the expander
  modport master (
    output in_valid, in_value, in_rt, out_ready,
    input  in_ready, out_valid, out_word, out_last
  );
endinterface

// File: rtl/li_expander.sv
// Converts a 32-bit constant + rt into the shortest MIPS load sequence (addiu | ori | lui | lui+ori).
// Latency: first word registered, valid the cycle after acceptance; one request in flight at a time.
// Backpressure: out_word/out_last/state hold while out_valid && !out_ready; in_ready only when idle.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high; drops any in-flight request
//   bus    - li_expander_if.slave (in_valid/in_ready/in_value/in_rt, out_valid/out_ready/out_word/out_last)
module li_expander #(
  parameter bit USE_ADDIU = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  li_expander_if.slave  bus
);

  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [1:0] {
    K_ADDIU,
    K_ORI0,
    K_LUI,
    K_PAIR
  } kind_e;

  typedef enum logic [1:0] {
    IDLE,
    EMIT1,
    EMIT2
  } state_e;

  // Priority-ordered choice of sequence for a constant.
  function automatic kind_e classify(input logic [31:0] v);
    kind_e k;
    if (USE_ADDIU && (v[31:16] == {16{v[15]}})) k = K_ADDIU;
    else if (v[31:16] == 16'h0000)              k = K_ORI0;
    else if (v[15:0] == 16'h0000)               k = K_LUI;
    else                                        k = K_PAIR;
    return k;
  endfunction

  state_e      state_q;
  logic [31:0] val_q;
  logic [4:0]  rt_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] out_word_q;
  logic        out_last_q;

  kind_e       kind_in_d;
  logic [31:0] first_word_d;
  logic        first_last_d;
  logic [31:0] orir_word_d;
  logic        pair_q_d;

  // First word is built straight from the incoming request so that it can be
  // registered in the accept cycle; it matches what the captured copy selects.
  always_comb begin
    kind_in_d    = classify(bus.in_value);
    first_word_d = {OP_LUI, 5'd0, bus.in_rt, bus.in_value[31:16]};
    unique case (kind_in_d)
      K_ADDIU: first_word_d = {OP_ADDIU, 5'd0, bus.in_rt, bus.in_value[15:0]};
      K_ORI0:  first_word_d = {OP_ORI,   5'd0, bus.in_rt, bus.in_value[15:0]};
      K_LUI:   first_word_d = {OP_LUI,   5'd0, bus.in_rt, bus.in_value[31:16]};
      K_PAIR:  first_word_d = {OP_LUI,   5'd0, bus.in_rt, bus.in_value[31:16]};
      default: first_word_d = {OP_LUI,   5'd0, bus.in_rt, bus.in_value[31:16]};
    endcase
    first_last_d = (kind_in_d != K_PAIR);
  end

  // Second half of a pair comes only from the captured request.
  assign orir_word_d = {OP_ORI, rt_q, rt_q, val_q[15:0]};
  assign pair_q_d    = (classify(val_q) == K_PAIR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      val_q       <= '0;
      rt_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            val_q       <= bus.in_value;
            rt_q        <= bus.in_rt;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_word_q  <= first_word_d;
            out_last_q  <= first_last_d;
            state_q     <= EMIT1;
          end
        end
        EMIT1: begin
          if (bus.out_ready) begin
            if (pair_q_d) begin
              out_word_q <= orir_word_d;
              out_last_q <= 1'b1;
              state_q    <= EMIT2;
            end else begin
              // Returning to IDLE here (not accepting) guarantees a gap cycle.
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end
        EMIT2: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_li_expander.sv
module tb_li_expander;

  logic        clk;
  logic        reset;
  logic        sel;        // 0: DUT with addiu enabled, 1: DUT with addiu disabled
  logic        in_valid;
  logic [31:0] in_value;
  logic [4:0]  in_rt;
  logic        out_ready;

  int tests;
  int fails;

  li_expander_if ifa();
  li_expander_if ifb();

  assign ifa.in_valid  = in_valid && !sel;
  assign ifb.in_valid  = in_valid && sel;
  assign ifa.in_value  = in_value;
  assign ifb.in_value  = in_value;
  assign ifa.in_rt     = in_rt;
  assign ifb.in_rt     = in_rt;
  assign ifa.out_ready = out_ready;
  assign ifb.out_ready = out_ready;

  wire        o_in_ready  = sel ? ifb.in_ready  : ifa.in_ready;
  wire        o_valid     = sel ? ifb.out_valid : ifa.out_valid;
  wire [31:0] o_word      = sel ? ifb.out_word  : ifa.out_word;
  wire        o_last      = sel ? ifb.out_last  : ifa.out_last;

  li_expander #(.USE_ADDIU(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  li_expander #(.USE_ADDIU(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] value;
    logic [4:0]  rt;
    int          nwords;
    logic [31:0] w0;
    logic        l0;
    logic [31:0] w1;
    logic        l1;
  } vec_t;

  vec_t vecs[14];

  // Full transaction with consumer always ready; returns collected words.
  task automatic run_req(input logic s, input logic [31:0] v, input logic [4:0] rt,
                         output int n, output logic [31:0] w0, output logic l0,
                         output logic [31:0] w1, output logic l1, output logic rdy_after,
                         output logic lat_ok);
    bit done;
    bit got_ready;
    n = 0; w0 = '0; l0 = 1'b0; w1 = '0; l1 = 1'b0; done = 0; got_ready = 0;
    sel = s;
    out_ready = 1'b0;
    for (int c = 0; c < 20 && !got_ready; c++) begin
      if (o_in_ready) got_ready = 1;
      else step();
    end
    in_valid = 1'b1;
    in_value = v;
    in_rt    = rt;
    step();
    in_valid = 1'b0;
    lat_ok   = got_ready && o_valid;
    out_ready = 1'b1;
    for (int c = 0; c < 6 && !done; c++) begin
      if (o_valid) begin
        if (n == 0) begin w0 = o_word; l0 = o_last; end
        else        begin w1 = o_word; l1 = o_last; end
        n++;
        if (o_last || n >= 3) done = 1;
      end
      step();
    end
    rdy_after = o_in_ready && !o_valid;
    out_ready = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] w0, w1;
    logic        l0, l1, rdy, lat;
    int          cyc;

    tests = 0; fails = 0;
    reset = 1'b1; sel = 1'b0; in_valid = 1'b0; in_value = '0; in_rt = '0; out_ready = 1'b0;

    vecs[0]  = '{1'b0, 32'h00000005, 5'd8,  1, 32'h24080005, 1'b1, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'hFFFF8000, 5'd9,  1, 32'h24098000, 1'b1, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000ABCD, 5'd8,  1, 32'h3408ABCD, 1'b1, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h12340000, 5'd8,  1, 32'h3C081234, 1'b1, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h12345678, 5'd8,  2, 32'h3C081234, 1'b0, 32'h35085678, 1'b1};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF, 5'd8,  2, 32'h3C08FFFF, 1'b0, 32'h3508FFFF, 1'b1};
    vecs[6]  = '{1'b0, 32'h00000000, 5'd8,  1, 32'h24080000, 1'b1, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'h00000000, 5'd8,  1, 32'h34080000, 1'b1, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 32'h00008000, 5'd8,  1, 32'h34088000, 1'b1, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'hFFFF0000, 5'd8,  1, 32'h3C08FFFF, 1'b1, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'hFFFFFFFF, 5'd0,  1, 32'h2400FFFF, 1'b1, 32'h0, 1'b0};
    vecs[11] = '{1'b1, 32'hFFFF8000, 5'd8,  2, 32'h3C08FFFF, 1'b0, 32'h35088000, 1'b1};
    vecs[12] = '{1'b0, 32'h00007FFF, 5'd31, 1, 32'h241F7FFF, 1'b1, 32'h0, 1'b0};
    vecs[13] = '{1'b1, 32'h00000005, 5'd8,  1, 32'h34080005, 1'b1, 32'h0, 1'b0};

    step(); step();
    reset = 1'b0;

    // Reset state of both instances
    chk("rst_a_in_ready",  {31'd0, ifa.in_ready},  32'd1);
    chk("rst_a_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("rst_a_out_word",  ifa.out_word,           32'd0);
    chk("rst_a_out_last",  {31'd0, ifa.out_last},  32'd0);
    chk("rst_b_in_ready",  {31'd0, ifb.in_ready},  32'd1);
    chk("rst_b_out_valid", {31'd0, ifb.out_valid}, 32'd0);

    foreach (vecs[i]) begin
      run_req(vecs[i].sel, vecs[i].value, vecs[i].rt, n, w0, l0, w1, l1, rdy, lat);
      chk($sformatf("v%0d_latency", i), {31'd0, lat}, 32'd1);
      chk($sformatf("v%0d_nwords", i), n, vecs[i].nwords);
      chk($sformatf("v%0d_w0", i), w0, vecs[i].w0);
      chk($sformatf("v%0d_l0", i), {31'd0, l0}, {31'd0, vecs[i].l0});
      if (vecs[i].nwords == 2) begin
        chk($sformatf("v%0d_w1", i), w1, vecs[i].w1);
        chk($sformatf("v%0d_l1", i), {31'd0, l1}, {31'd0, vecs[i].l1});
      end
      chk($sformatf("v%0d_ready_after", i), {31'd0, rdy}, 32'd1);
      step();
    end

    // Stall: lui word held for 3 cycles while inputs change, then orir.
    sel = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_value = 32'h12345678; in_rt = 5'd8;
    step();
    in_value = 32'h00000001; in_rt = 5'd3;   // must be ignored while busy
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d_valid", c), {31'd0, o_valid}, 32'd1);
      chk($sformatf("stall%0d_word", c), o_word, 32'h3C081234);
      chk($sformatf("stall%0d_last", c), {31'd0, o_last}, 32'd0);
      chk($sformatf("stall%0d_in_ready", c), {31'd0, o_in_ready}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall_release_word", o_word, 32'h3C081234);
    step();
    chk("stall_orir_word", o_word, 32'h35085678);
    chk("stall_orir_last", {31'd0, o_last}, 32'd1);
    step();
    chk("stall_done_valid", {31'd0, o_valid}, 32'd0);
    chk("stall_done_ready", {31'd0, o_in_ready}, 32'd1);
    out_ready = 1'b0;
    step();

    // Reset while in EMIT2: pair must not complete.
    in_valid = 1'b1; in_value = 32'h12345678; in_rt = 5'd8;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("emit2_word_before_reset", o_word, 32'h35085678);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_emit2_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_emit2_ready", {31'd0, o_in_ready}, 32'd1);
    out_ready = 1'b1;
    cyc = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_valid) cyc++;
      step();
    end
    chk("rst_emit2_no_orir", cyc, 0);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
